// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, BCD limits and counter width for the alarm stage.
// Shared by alarm_module and bcd2_wrap_counter.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam int         CNT_W    = 9;

    function automatic logic [7:0] bcd2_inc(
        input logic [7:0] v,
        input logic [7:0] max
    );
        if (v >= max)
            return 8'h00;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_module_bcd2_wrap_counter.sv
// bcd2_wrap_counter: two-digit BCD incrementer wrapping MAX -> 00,
// with a synchronous load that takes priority over the increment.
module bcd2_wrap_counter
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (load)
            value <= load_val;
        else if (inc)
            value <= bcd2_inc(value, MAX);
    end

endmodule

// File: rtl/alarm_module.sv
// alarm_module: alarm time storage and arm/ring/snooze FSM driving the buzzer path.
// Optional ALARM_WEEKDAY_EN: when defined, weekend days (Day 5, 6) never start a ring.
module alarm_module
    import alarm_pkg::*;
#(
    parameter int         RING_SEC   = 60,
    parameter int         SNOOZE_SEC = 300,
    parameter logic [7:0] INIT_HOUR  = 8'h07,
    parameter logic [7:0] INIT_MIN   = 8'h00
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic [3:0] SecH,
    input  logic [3:0] SecL,
    input  logic [3:0] MinH,
    input  logic [3:0] MinL,
    input  logic [3:0] HourH,
    input  logic [3:0] HourL,
    input  logic [2:0] Day,
    input  logic       ArmEn,
    input  logic       SetMode,
    input  logic       IncHour,
    input  logic       IncMin,
    input  logic       Snooze,
    input  logic       Stop,
    output logic [3:0] AlarmHourH,
    output logic [3:0] AlarmHourL,
    output logic [3:0] AlarmMinH,
    output logic [3:0] AlarmMinL,
    output logic       Ringing,
    output logic       AlarmOn,
    output logic [1:0] State
);

    localparam logic [CNT_W-1:0] RING_LD = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNZ_LD  = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [7:0]       alarm_hour;
    logic [7:0]       alarm_min;
    logic [3:0]       secl_d;
    logic             tick;
    logic             day_ok;
    logic             match;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] ring_q;
    logic [CNT_W-1:0] ring_d;
    logic [CNT_W-1:0] snz_q;
    logic [CNT_W-1:0] snz_d;
    logic             ringing_q;
    logic             alarm_on_q;

    bcd2_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (CLK),
        .load     (Rst),
        .load_val (INIT_HOUR),
        .inc      (SetMode & IncHour),
        .value    (alarm_hour)
    );

    bcd2_wrap_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (CLK),
        .load     (Rst),
        .load_val (INIT_MIN),
        .inc      (SetMode & IncMin),
        .value    (alarm_min)
    );

`ifdef ALARM_WEEKDAY_EN
    assign day_ok = (Day <= 3'd4);
`else
    logic unused_day;
    assign unused_day = ^Day;
    assign day_ok     = 1'b1;
`endif

    assign tick  = (SecL != secl_d);
    // Only the tick into :00 can match, so a Stop held at :00 cannot retrigger.
    assign match = tick && (SecH == 4'd0) && (SecL == 4'd0)
                && ({HourH, HourL} == alarm_hour)
                && ({MinH, MinL} == alarm_min)
                && !SetMode && day_ok;

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!ArmEn) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match) begin
                        state_d = ST_RINGING;
                        ring_d  = RING_LD;
                    end
                end
                ST_RINGING: begin
                    if (Stop) begin
                        state_d = ST_ARMED;
                    end else if (Snooze) begin
                        state_d = ST_SNOOZE;
                        snz_d   = SNZ_LD;
                    end else if (tick) begin
                        if (ring_q == ONE)
                            state_d = ST_ARMED;
                        else
                            ring_d = ring_q - ONE;
                    end
                end
                ST_SNOOZE: begin
                    if (Stop) begin
                        state_d = ST_ARMED;
                    end else if (tick) begin
                        if (snz_q == ONE) begin
                            state_d = ST_RINGING;
                            ring_d  = RING_LD;
                        end else begin
                            snz_d = snz_q - ONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            ring_q     <= '0;
            snz_q      <= '0;
            ringing_q  <= 1'b0;
            alarm_on_q <= 1'b0;
            secl_d     <= SecL;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            ringing_q  <= (state_d == ST_RINGING);
            alarm_on_q <= (state_d != ST_IDLE);
            secl_d     <= SecL;
        end
    end

    assign {AlarmHourH, AlarmHourL} = alarm_hour;
    assign {AlarmMinH, AlarmMinL}   = alarm_min;
    assign Ringing = ringing_q;
    assign AlarmOn = alarm_on_q;
    assign State   = state_q;

endmodule

// File: tb/tb_alarm_module.sv
// tb_alarm_module: directed scenarios plus randomized traffic for alarm_module,
// checked every cycle against a time-of-day level model of the alarm.
module tb_alarm_module;

    localparam int RING = 5;
    localparam int SNZ  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] sec_h, sec_l, min_h, min_l, hour_h, hour_l;
    logic [2:0] day;
    logic       arm_en, set_mode, inc_hour, inc_min, snooze, stop;
    logic [3:0] a_hh, a_hl, a_mh, a_ml;
    logic       ringing, alarm_on;
    logic [1:0] state;

    int tod;
    int total = 0;
    int bad   = 0;

    alarm_module #(
        .RING_SEC   (RING),
        .SNOOZE_SEC (SNZ),
        .INIT_HOUR  (8'h07),
        .INIT_MIN   (8'h00)
    ) dut (
        .CLK        (clk),
        .Rst        (rst),
        .SecH       (sec_h),
        .SecL       (sec_l),
        .MinH       (min_h),
        .MinL       (min_l),
        .HourH      (hour_h),
        .HourL      (hour_l),
        .Day        (day),
        .ArmEn      (arm_en),
        .SetMode    (set_mode),
        .IncHour    (inc_hour),
        .IncMin     (inc_min),
        .Snooze     (snooze),
        .Stop       (stop),
        .AlarmHourH (a_hh),
        .AlarmHourL (a_hl),
        .AlarmMinH  (a_mh),
        .AlarmMinL  (a_ml),
        .Ringing    (ringing),
        .AlarmOn    (alarm_on),
        .State      (state)
    );

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tod(int t);
        tod = t % 86400;
        {hour_h, hour_l} = bcd(tod / 3600);
        {min_h, min_l}   = bcd((tod / 60) % 60);
        {sec_h, sec_l}   = bcd(tod % 60);
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic next_sec();
        set_tod(tod + 1);
        cyc();
    endtask

    task automatic pulse_min();
        inc_min = 1'b1;
        cyc();
        inc_min = 1'b0;
    endtask

    task automatic pulse_hour();
        inc_hour = 1'b1;
        cyc();
        inc_hour = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    // Model: alarm time as hour/minute integers, state 0..3, remaining seconds.
    int m_ah, m_am, m_st, m_ring, m_snz, m_prev_s;
    bit m_valid = 1'b0;

    task automatic model_step();
        int  s_units;
        bit  tick, match, day_ok;
        s_units = tod % 10;
        if (rst) begin
            m_ah = 7; m_am = 0; m_st = 0;
            m_ring = 0; m_snz = 0;
            m_prev_s = s_units;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid)
            return;
        tick = (s_units != m_prev_s);
        m_prev_s = s_units;
        day_ok = 1'b1;
`ifdef ALARM_WEEKDAY_EN
        day_ok = (day <= 3'd4);
`endif
        match = tick && (tod % 60 == 0) && (tod / 3600 == m_ah)
             && ((tod / 60) % 60 == m_am) && !set_mode && day_ok;
        if (!arm_en) begin
            m_st = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (match) begin m_st = 2; m_ring = RING; end
        end else if (m_st == 2) begin
            if (stop) m_st = 1;
            else if (snooze) begin m_st = 3; m_snz = SNZ; end
            else if (tick) begin
                m_ring--;
                if (m_ring == 0) m_st = 1;
            end
        end else begin
            if (stop) m_st = 1;
            else if (tick) begin
                m_snz--;
                if (m_snz == 0) begin m_st = 2; m_ring = RING; end
            end
        end
        if (set_mode && inc_hour) m_ah = (m_ah + 1) % 24;
        if (set_mode && inc_min)  m_am = (m_am + 1) % 60;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check("state", state, m_st);
            check("ringing", ringing, m_st == 2);
            check("alarm_on", alarm_on, m_st != 0);
            check("alarm_hour", {a_hh, a_hl}, bcd(m_ah));
            check("alarm_min", {a_mh, a_ml}, bcd(m_am));
        end
    end

    initial begin
        arm_en = 0; set_mode = 0; inc_hour = 0; inc_min = 0;
        snooze = 0; stop = 0; day = 3'd0;
        set_tod(12 * 3600);
        cyc(3);
        check("rst_state", state, 0);
        check("rst_ringing", ringing, 0);
        check("rst_alarm_on", alarm_on, 0);
        check("rst_digits", {a_hh, a_hl, a_mh, a_ml}, 16'h0700);
        rst = 1'b0;
        cyc(2);

        set_mode = 1'b1;
        repeat (3) pulse_min();
        check("edit_min", {a_hh, a_hl, a_mh, a_ml}, 16'h0703);
        repeat (17) pulse_hour();
        check("edit_hour_wrap", {a_hh, a_hl, a_mh, a_ml}, 16'h0003);
        repeat (7) pulse_hour();
        repeat (57) pulse_min();
        check("edit_min_wrap", {a_hh, a_hl, a_mh, a_ml}, 16'h0700);
        set_mode = 1'b0;

        arm_en = 1'b1;
        cyc(2);
        check("armed", state, 1);
        set_tod(6 * 3600 + 59 * 60 + 57);
        cyc(2);
        next_sec(); cyc();
        next_sec(); cyc();
        next_sec();
        check("ring_rise_state", state, 2);
        check("ring_rise", ringing, 1);
        cyc();
        for (int i = 0; i < RING - 1; i++) begin
            next_sec(); cyc();
        end
        check("ring_last_tick", state, 2);
        next_sec();
        check("ring_auto_stop", state, 1);
        check("ring_auto_stop_r", ringing, 0);

        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        set_tod(7 * 3600 + 59);
        cyc(2);
        next_sec();
        check("ring2", state, 2);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        check("snooze_state", state, 3);
        check("snooze_ringing", ringing, 0);
        for (int i = 0; i < SNZ - 1; i++) begin
            next_sec(); cyc();
        end
        check("snooze_hold", state, 3);
        next_sec();
        check("rering", ringing, 1);
        cyc();
        stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
        check("stop_wins", state, 1);
        check("stop_wins_r", ringing, 0);

        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        set_tod(7 * 3600 + 60 + 59);
        cyc(2);
        next_sec();
        check("ring3", state, 2);
        pulse_stop();
        check("stop_at_00", state, 1);
        cyc(3);
        check("no_retrigger_00", ringing, 0);
        for (int i = 0; i < 59; i++) next_sec();
        check("no_retrigger_59", ringing, 0);

        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        next_sec();
        check("ring4", state, 2);
        arm_en = 1'b0; cyc();
        check("disarm_state", state, 0);
        check("disarm_ringing", ringing, 0);
        check("disarm_on", alarm_on, 0);
        arm_en = 1'b1; cyc(2);
        set_mode = 1'b1; pulse_min();
        set_tod(7 * 3600 + 3 * 60 + 59);
        cyc(2);
        next_sec();
        check("setmode_blocks", state, 1);
        set_mode = 1'b0; cyc(2);

        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        day = 3'd5;
        set_tod(7 * 3600 + 4 * 60 + 59);
        cyc(2);
        next_sec();
`ifdef ALARM_WEEKDAY_EN
        check("day5", state, 1);
`else
        check("day5", state, 2);
`endif
        pulse_stop();
        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        day = 3'd2;
        set_tod(7 * 3600 + 5 * 60 + 59);
        cyc(2);
        next_sec();
        check("day2", state, 2);
        pulse_stop();
        set_mode = 1'b1; pulse_min(); set_mode = 1'b0;
        day = 3'd6;
        set_tod(7 * 3600 + 6 * 60 + 59);
        cyc(2);
        next_sec();
`ifdef ALARM_WEEKDAY_EN
        check("day6", state, 1);
`else
        check("day6", state, 2);
`endif
        pulse_stop();

        for (int i = 0; i < 6000; i++) begin
            arm_en   = ($urandom_range(0, 59) != 0);
            set_mode = ($urandom_range(0, 19) == 0);
            inc_hour = ($urandom_range(0, 5) == 0);
            inc_min  = ($urandom_range(0, 3) == 0);
            snooze   = ($urandom_range(0, 14) == 0);
            stop     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0)
                day = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0)
                set_tod(m_ah * 3600 + m_am * 60 + 86400
                        - int'($urandom_range(0, 3)));
            else if ($urandom_range(0, 2) == 0)
                set_tod(tod + 1);
            cyc();
        end
        arm_en = 0; set_mode = 0; inc_hour = 0; inc_min = 0;
        snooze = 0; stop = 0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
